// File: rtl/line_fetcher.sv
// line_fetcher: prefetches framebuffer lines into ping-pong buffers and
// replays them scaled, with syncs re-aligned to the 2-cycle rgb latency.
//   clk, reset (async, active-low)
//   hpos, vpos, display_on : beam position from sync generator
//   hsync_in, vsync_in     : syncs, one cycle behind hpos/vpos
//   mem_req/addr/ack/rdata : one-word-per-ack read port
//   rgb, hsync_out, vsync_out : monitor pins
//   underrun               : sticky late-fetch flag
module line_fetcher #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int SCALE     = 2,
  parameter int ADDR_W    = 17,
  parameter int FB_BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              underrun
);

  localparam int FB_WIDTH  = H_DISPLAY / SCALE;
  localparam int FB_HEIGHT = V_DISPLAY / SCALE;
  localparam int SH        = $clog2(SCALE);
  localparam int XW        = $clog2(FB_WIDTH);

  localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
  localparam logic [9:0] VD    = 10'(V_DISPLAY);
  localparam logic [9:0] FBH   = 10'(FB_HEIGHT);
  localparam logic [9:0] FBW   = 10'(FB_WIDTH);
  localparam logic [9:0] SMASK = 10'(SCALE - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FB_BASE);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic              wsel_q, wsel_d;
  logic [1:0]        valid_q, valid_d;
  logic              under_q, under_d;
  logic              lok_q, lok_d;
  logic              de1_q, de1_d;
  logic              ok1_q, ok1_d;
  logic [15:0]       rgb_q, rgb_d;
  logic              hs_q, vs_q;
  logic [15:0]       rd_q;
  logic              wr_en;

  logic [9:0]    vsrc, nsrc, rx;
  logic [XW-1:0] ridx;
  logic          vis, sol, trig;
  logic [9:0]    trig_s;

  logic [15:0] lbuf [2][FB_WIDTH];

  assign vsrc = vpos >> SH;
  assign nsrc = vsrc + 10'd1;
  assign rx   = hpos >> SH;
  assign ridx = (rx < FBW) ? rx[XW-1:0] : '0;
  assign vis  = vpos < VD;
  assign sol  = hpos == '0;

  always_comb begin
    trig   = 1'b0;
    trig_s = '0;
    if (sol) begin
      unique case (1'b1)
        vpos == VD: trig = 1'b1;
        vis && ((vpos & SMASK) == '0)
          && (nsrc < FBH): begin
          trig   = 1'b1;
          trig_s = nsrc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    wsel_d  = wsel_q;
    valid_d = valid_q;
    under_d = under_q;
    wr_en   = 1'b0;
    lok_d   = lok_q;
    de1_d   = display_on && vis;
    ok1_d   = 1'b0;
    rgb_d   = '0;

    if (state_q == FETCH && mem_ack)
      wr_en = 1'b1;

    // a new trigger always wins; an unfinished
    // fetch is dropped and its buffer stays invalid
    if (trig) begin
      if (state_q == FETCH)
        under_d = 1'b1;
      state_d           = FETCH;
      wsel_d            = trig_s[0];
      valid_d[trig_s[0]] = 1'b0;
      addr_d = BASE
        + ADDR_W'(trig_s * FB_WIDTH);
      x_d    = '0;
    end else if (wr_en) begin
      if (x_q == X_LAST) begin
        state_d         = IDLE;
        valid_d[wsel_q] = 1'b1;
      end else begin
        x_d    = x_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end

    // line verdict is frozen at hpos 0 so a
    // late fetch cannot pop in mid-line
    if (sol) begin
      lok_d = valid_q[vsrc[0]];
      if (vis && !valid_q[vsrc[0]])
        under_d = 1'b1;
    end
    ok1_d = lok_d && valid_q[vsrc[0]];

    if (de1_q && ok1_q)
      rgb_d = rd_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      wsel_q  <= 1'b0;
      valid_q <= '0;
      under_q <= 1'b0;
      lok_q   <= 1'b0;
      de1_q   <= 1'b0;
      ok1_q   <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      wsel_q  <= wsel_d;
      valid_q <= valid_d;
      under_q <= under_d;
      lok_q   <= lok_d;
      de1_q   <= de1_d;
      ok1_q   <= ok1_d;
      rgb_q   <= rgb_d;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      lbuf[wsel_q][x_q] <= mem_rdata;
    rd_q <= lbuf[vsrc[0]][ridx];
  end

  assign mem_req   = state_q == FETCH;
  assign mem_addr  = addr_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign underrun  = under_q;

endmodule

// File: tb/tb_line_fetcher.sv
// tb_line_fetcher: scoreboard bench for line_fetcher on a small raster,
// memory returns addr[15:0] with a programmable ack period.
module tb_line_fetcher;

  localparam int HD   = 32;
  localparam int VD   = 16;
  localparam int SC   = 2;
  localparam int AW   = 17;
  localparam int BASE = 100;
  localparam int HT   = 48;
  localparam int VT   = 22;
  localparam int FBW  = HD / SC;
  localparam int FBH  = VD / SC;
  localparam int HS0  = 36;
  localparam int HS1  = 40;
  localparam int VS0  = 18;
  localparam int VS1  = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    hpos, vpos;
  logic          display_on;
  logic          hsync_in, vsync_in;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic [15:0]   rgb;
  logic          hsync_out, vsync_out;
  logic          underrun;

  line_fetcher #(
    .H_DISPLAY(HD),
    .V_DISPLAY(VD),
    .SCALE(SC),
    .ADDR_W(AW),
    .FB_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .display_on(display_on),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .rgb(rgb),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  int h, v, period, mcnt, bx, bsel;
  bit hs_nxt, vs_nxt;
  bit bfetch, bunder, bline_ok;
  bit [1:0] bvalid;
  logic [AW-1:0] baddr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    bfetch   = 1'b0;
    bunder   = 1'b0;
    bline_ok = 1'b0;
    bvalid   = '0;
    bx       = 0;
    bsel     = 0;
    mcnt     = 0;
    q.delete();
  endtask

  task automatic step();
    exp_t e;
    int   s, sel;
    bit   trig, ack, disp;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("rgb", rgb, e.rgb);
      chk("hsync_out", hsync_out, e.hs);
      chk("vsync_out", vsync_out, e.vs);
    end
    chk("mem_req", mem_req, bfetch);
    if (bfetch)
      chk("mem_addr", mem_addr, baddr);
    chk("underrun", underrun, bunder);

    disp       = (h < HD) && (v < VD);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = disp;
    hsync_in   = hs_nxt;
    vsync_in   = vs_nxt;
    hs_nxt     = (h >= HS0) && (h < HS1);
    vs_nxt     = (v >= VS0) && (v < VS1);

    sel = (v / SC) % 2;
    if (h == 0 && v < VD)
      bline_ok = bvalid[sel];
    e.hs  = (h >= HS0) && (h < HS1);
    e.vs  = (v >= VS0) && (v < VS1);
    e.rgb = (disp && bline_ok && bvalid[sel])
      ? 16'(BASE + (v / SC) * FBW + h / SC) : 16'h0;
    q.push_back(e);

    if (mem_req) begin
      ack  = (mcnt == period - 1);
      mcnt = ack ? 0 : mcnt + 1;
    end else begin
      ack  = 1'b0;
      mcnt = 0;
    end
    mem_ack   = ack;
    mem_rdata = mem_addr[15:0];

    trig = 1'b0;
    s    = 0;
    if (h == 0) begin
      if (v == VD)
        trig = 1'b1;
      else if (v < VD && v % SC == 0
               && v / SC + 1 < FBH) begin
        trig = 1'b1;
        s    = v / SC + 1;
      end
    end
    if (h == 0 && v < VD && !bvalid[sel])
      bunder = 1'b1;
    if (trig) begin
      if (bfetch)
        bunder = 1'b1;
      bfetch         = 1'b1;
      bsel           = s % 2;
      bvalid[s % 2]  = 1'b0;
      baddr          = AW'(BASE + s * FBW);
      bx             = 0;
    end else if (bfetch && ack) begin
      if (bx == FBW - 1) begin
        bfetch       = 1'b0;
        bvalid[bsel] = 1'b1;
      end else begin
        bx++;
        baddr++;
      end
    end

    h++;
    if (h == HT) begin
      h = 0;
      v++;
      if (v == VT)
        v = 0;
    end
  endtask

  initial begin
    bit found;
    int pv;
    reset      = 1'b0;
    hpos       = '0;
    vpos       = 10'(VD + 1);
    display_on = 1'b1;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    mem_ack    = 1'b1;
    mem_rdata  = 16'hffff;
    h      = 0;
    v      = VD;
    hs_nxt = 1'b0;
    vs_nxt = 1'b0;
    period = 1;
    baddr  = '0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync_out, 0);
    chk("rst_vsync", vsync_out, 0);
    chk("rst_underrun", underrun, 0);
    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    mem_ack  = 1'b0;

    period = 1;
    repeat (HT * VT + 100) step();
    chk("underrun_fast", underrun, 0);

    period = 4;
    repeat (HT * VT) step();
    chk("underrun_wait3", underrun, 0);

    period = 8;
    repeat (HT * VT) step();
    chk("underrun_slow", underrun, 1);

    period = 4;
    found  = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      found = bfetch && (bx >= 3)
        && (v < VD - 2);
    end
    chk("wait_fetch", found, 1);

    #2 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_underrun", underrun, 0);
    model_clear();
    #4 reset = 1'b1;

    pv = v;
    for (int i = 0; i < 2 * HT
         && !(v != pv && h == 2); i++)
      step();
    chk("underrun_post_rst", underrun, 1);

    repeat (HT * VT) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
